player_input_ctrl: RTL and testbench

PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

---
 rtl/player_input_ctrl.sv | 166 ++++++++++++++++
 tb/tb_player_input_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/player_input_ctrl.sv
// -----------------------------------------------------------------------------
// player_input_ctrl
//   Turns the NIOS keycode stream into registered player controls for the
//   battle stage: movement levels, a frame-aligned jump request, a rate-limited
//   fire pulse, and a fight/restart pulse for stage control.
//
// Ports
//   Clk             in   system clock, all state changes on its rising edge
//   Reset           in   synchronous, active-low reset
//   frame_clk       in   VGA_VS level (Clk-synchronous); a frame starts on its rise
//   keycode[7:0]    in   current key, 8'h00 = no key
//   enable          in   battle stage active
//   Left / Right    out  movement levels (1-Clk latency)
//   Up              out  jump request, held until the next frame boundary
//   Shoot           out  single-Clk fire pulse
//   Fight           out  single-Clk start/restart pulse
//   cooldown_active out  high while shooting is locked out
// -----------------------------------------------------------------------------
module player_input_ctrl #(
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter logic [7:0]  KEY_LEFT        = 8'h04,
  parameter logic [7:0]  KEY_RIGHT       = 8'h07,
  parameter logic [7:0]  KEY_UP          = 8'h1A,
  parameter logic [7:0]  KEY_SHOOT       = 8'h2C,
  parameter logic [7:0]  KEY_START       = 8'h28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       enable,
  output logic       Left,
  output logic       Right,
  output logic       Up,
  output logic       Shoot,
  output logic       Fight,
  output logic       cooldown_active
);

  // A zero-frame cooldown still needs a one-bit counter to be legal.
  localparam int unsigned CNT_W = (COOLDOWN_FRAMES > 32'd0) ? $clog2(COOLDOWN_FRAMES + 32'd1) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_FIRE     = 2'd1,
    ST_COOLDOWN = 2'd2
  } shoot_state_e;

  shoot_state_e   state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]     prev_key_r;
  logic           fc_q_r;

  logic           frame_rise_s;
  logic           up_press_s;
  logic           shoot_press_s;
  logic           start_press_s;

  // A press is the first Clk on which the key appears; holding it never re-fires.
  function automatic logic press_edge(input logic [7:0] cur,
                                      input logic [7:0] prev,
                                      input logic [7:0] key);
    return (cur == key) && (prev != key);
  endfunction

  assign frame_rise_s  = frame_clk && !fc_q_r;
  assign up_press_s    = press_edge(keycode, prev_key_r, KEY_UP);
  assign shoot_press_s = press_edge(keycode, prev_key_r, KEY_SHOOT);
  assign start_press_s = press_edge(keycode, prev_key_r, KEY_START);

  // Edge-detect history, movement levels, jump request and fight pulse.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // fc_q resets high so a frame_clk that is already high at release is not a rise;
      // prev_key resets to 00 so a key held through reset counts as a fresh press.
      prev_key_r <= 8'h00;
      fc_q_r     <= 1'b1;
      Left       <= 1'b0;
      Right      <= 1'b0;
      Up         <= 1'b0;
      Fight      <= 1'b0;
    end else begin
      prev_key_r <= keycode;
      fc_q_r     <= frame_clk;
      Left       <= enable && (keycode == KEY_LEFT);
      Right      <= enable && (keycode == KEY_RIGHT);
      Fight      <= start_press_s;
      // Set beats the frame clear so a jump pressed on a frame edge waits for the next frame.
      if (!enable) begin
        Up <= 1'b0;
      end else if (up_press_s) begin
        Up <= 1'b1;
      end else if (frame_rise_s) begin
        Up <= 1'b0;
      end else begin
        Up <= Up;
      end
    end
  end

  // Shoot FSM: fire pulse, frame-counted cooldown and lockout flag.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r         <= ST_READY;
      cnt_r           <= CNT_ZERO;
      Shoot           <= 1'b0;
      cooldown_active <= 1'b0;
    end else begin
      case (state_r)
        ST_READY: begin
          cnt_r <= CNT_ZERO;
          if (shoot_press_s && enable) begin
            state_r         <= ST_FIRE;
            Shoot           <= 1'b1;
            cooldown_active <= 1'b1;
          end else begin
            state_r         <= ST_READY;
            Shoot           <= 1'b0;
            cooldown_active <= 1'b0;
          end
        end
        ST_FIRE: begin
          // Load ignores any coincident frame_rise so the full cooldown is served.
          Shoot <= 1'b0;
          cnt_r <= CNT_LOAD;
          if (COOLDOWN_FRAMES == 32'd0) begin
            state_r         <= ST_READY;
            cooldown_active <= 1'b0;
          end else begin
            state_r         <= ST_COOLDOWN;
            cooldown_active <= 1'b1;
          end
        end
        ST_COOLDOWN: begin
          // Presses are dropped here, not queued; counting continues regardless of enable.
          Shoot <= 1'b0;
          if (frame_rise_s) begin
            if (cnt_r <= CNT_ONE) begin
              cnt_r           <= CNT_ZERO;
              state_r         <= ST_READY;
              cooldown_active <= 1'b0;
            end else begin
              cnt_r           <= cnt_r - CNT_ONE;
              state_r         <= ST_COOLDOWN;
              cooldown_active <= 1'b1;
            end
          end else begin
            cnt_r           <= cnt_r;
            state_r         <= ST_COOLDOWN;
            cooldown_active <= 1'b1;
          end
        end
        default: begin
          state_r         <= ST_READY;
          cnt_r           <= CNT_ZERO;
          Shoot           <= 1'b0;
          cooldown_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_input_ctrl
//   Self-checking bench for player_input_ctrl with COOLDOWN_FRAMES = 3.
//   Each driven cycle pushes the expected outputs onto a scoreboard queue; the
//   entry is popped and compared once the DUT has registered that cycle.
// -----------------------------------------------------------------------------
module tb_player_input_ctrl;

  localparam int CD = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       enable = 1'b0;
  logic       Left, Right, Up, Shoot, Fight, cooldown_active;

  player_input_ctrl #(.COOLDOWN_FRAMES(CD)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_clk       (frame_clk),
    .keycode         (keycode),
    .enable          (enable),
    .Left            (Left),
    .Right           (Right),
    .Up              (Up),
    .Shoot           (Shoot),
    .Fight           (Fight),
    .cooldown_active (cooldown_active)
  );

  // Free-running 100 MHz system clock.
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic lft;
    logic rgt;
    logic up;
    logic shoot;
    logic fight;
    logic cda;
  } exp_t;

  exp_t sb_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int n_shoot   = 0;
  int n_fight   = 0;
  int n_up_rise = 0;
  logic up_last = 1'b0;

  // Reference model state (behavioural view of the controls).
  logic [7:0] m_prev = 8'h00;
  logic       m_fcq  = 1'b1;
  logic       m_up   = 1'b0;
  logic       m_fire = 1'b0;
  int         m_cd   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one Clk of stimulus, predict the registered outputs, then compare.
  task automatic cyc(input logic [7:0] key, input logic en, input logic fc, input logic rst);
    exp_t e;
    logic rise;
    keycode   = key;
    enable    = en;
    frame_clk = fc;
    Reset     = rst;
    e = '0;
    if (!rst) begin
      m_prev = 8'h00;
      m_fcq  = 1'b1;
      m_up   = 1'b0;
      m_fire = 1'b0;
      m_cd   = 0;
    end else begin
      rise    = fc && !m_fcq;
      e.lft   = en && (key == 8'h04);
      e.rgt   = en && (key == 8'h07);
      if (!en)                                 m_up = 1'b0;
      else if (key == 8'h1A && m_prev != 8'h1A) m_up = 1'b1;
      else if (rise)                           m_up = 1'b0;
      e.up    = m_up;
      e.fight = (key == 8'h28) && (m_prev != 8'h28);
      if (m_fire) begin
        m_fire = 1'b0;
        m_cd   = CD;
      end else if (m_cd > 0) begin
        if (rise) m_cd = m_cd - 1;
      end else if (en && key == 8'h2C && m_prev != 8'h2C) begin
        m_fire  = 1'b1;
        e.shoot = 1'b1;
      end
      e.cda  = m_fire || (m_cd > 0);
      m_prev = key;
      m_fcq  = fc;
    end
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check_eq("Left",            {31'd0, Left},            {31'd0, e.lft});
    check_eq("Right",           {31'd0, Right},           {31'd0, e.rgt});
    check_eq("Up",              {31'd0, Up},              {31'd0, e.up});
    check_eq("Shoot",           {31'd0, Shoot},           {31'd0, e.shoot});
    check_eq("Fight",           {31'd0, Fight},           {31'd0, e.fight});
    check_eq("cooldown_active", {31'd0, cooldown_active}, {31'd0, e.cda});
    if (Left === 1'b1 && Right === 1'b1) check_eq("left_right_exclusive", 32'd1, 32'd0);
    if (Shoot === 1'b1) n_shoot++;
    if (Fight === 1'b1) n_fight++;
    if (Up === 1'b1 && up_last !== 1'b1) n_up_rise++;
    up_last = Up;
  endtask

  // One frame: frame_clk high for 2 Clk, low for 3 Clk, key held throughout.
  task automatic frames(input logic [7:0] key, input logic en, input int n);
    for (int f = 0; f < n; f++) begin
      cyc(key, en, 1'b1, 1'b1);
      cyc(key, en, 1'b1, 1'b1);
      cyc(key, en, 1'b0, 1'b1);
      cyc(key, en, 1'b0, 1'b1);
      cyc(key, en, 1'b0, 1'b1);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) cyc(8'h00, 1'b0, 1'b0, 1'b0);

    // Movement levels and enable gating.
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (2) cyc(8'h04, 1'b1, 1'b0, 1'b1);
    repeat (2) cyc(8'h04, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);

    // Single fire pulse, presses during cooldown ignored, press after fires.
    n_shoot = 0;
    cyc(8'h2C, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    check_eq("shoot_first_press", n_shoot, 32'd1);
    n_shoot = 0;
    for (int f = 0; f < 3; f++) begin
      cyc(8'h2C, 1'b1, 1'b0, 1'b1);
      cyc(8'h00, 1'b1, 1'b0, 1'b1);
      cyc(8'h2C, 1'b1, 1'b1, 1'b1);
      cyc(8'h00, 1'b1, 1'b1, 1'b1);
      cyc(8'h00, 1'b1, 1'b0, 1'b1);
    end
    check_eq("shoot_during_cooldown", n_shoot, 32'd0);
    check_eq("cooldown_after_3_rises", {31'd0, cooldown_active}, 32'd0);
    n_shoot = 0;
    cyc(8'h2C, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    check_eq("shoot_after_cooldown", n_shoot, 32'd1);
    frames(8'h00, 1'b1, 4);

    // Press coinciding with frame_rise: load wins, 3 further rises needed.
    n_shoot = 0;
    frames(8'h2C, 1'b1, 1);
    frames(8'h00, 1'b1, 2);
    check_eq("cooldown_after_2_more", {31'd0, cooldown_active}, 32'd1);
    frames(8'h00, 1'b1, 1);
    check_eq("cooldown_after_3_more", {31'd0, cooldown_active}, 32'd0);
    check_eq("shoot_coincident_count", n_shoot, 32'd1);

    // Jump pressed on a frame edge, held for 10 frames.
    n_up_rise = 0;
    frames(8'h1A, 1'b1, 10);
    check_eq("up_once_when_held", n_up_rise, 32'd1);
    check_eq("up_cleared_end", {31'd0, Up}, 32'd0);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);

    // Fight while disabled, no auto-repeat; shooting locked out when disabled.
    n_fight = 0;
    repeat (100) cyc(8'h28, 1'b0, 1'b0, 1'b1);
    check_eq("fight_once_held", n_fight, 32'd1);
    n_shoot = 0;
    repeat (3) cyc(8'h2C, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("shoot_disabled", n_shoot, 32'd0);
    check_eq("cooldown_disabled", {31'd0, cooldown_active}, 32'd0);

    // Reset mid-cooldown with frame_clk high and a pending jump.
    cyc(8'h2C, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b1, 1'b1);
    cyc(8'h1A, 1'b1, 1'b1, 1'b1);
    check_eq("up_pending_before_reset", {31'd0, Up}, 32'd1);
    check_eq("cooldown_before_reset", {31'd0, cooldown_active}, 32'd1);
    repeat (2) cyc(8'h2C, 1'b1, 1'b1, 1'b0);
    check_eq("up_after_reset", {31'd0, Up}, 32'd0);
    check_eq("cooldown_after_reset", {31'd0, cooldown_active}, 32'd0);
    n_shoot = 0;
    cyc(8'h2C, 1'b1, 1'b1, 1'b1);
    check_eq("held_space_fires_on_release", {31'd0, Shoot}, 32'd1);
    repeat (3) cyc(8'h2C, 1'b1, 1'b1, 1'b1);
    check_eq("held_space_single_shot", n_shoot, 32'd1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
